// File: rtl/skin_width_if.sv
// Luma-in / cluster-width-out handshake bundle for skin_width_pipe.
// The master side drives luma and consumes widths; the slave side is the pipeline.
interface skin_width_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16
) ();
  logic [DATA_W-1:0] y;
  logic              y_valid;
  logic              y_ready;
  logic              const_mode;
  logic [OUT_W-1:0]  width_cb;
  logic [OUT_W-1:0]  width_cr;
  logic [1:0]        region;
  logic              width_valid;
  logic              width_ready;

  modport master (
    output y, y_valid, const_mode, width_ready,
    input  y_ready, width_cb, width_cr, region, width_valid
  );

  modport slave (
    input  y, y_valid, const_mode, width_ready,
    output y_ready, width_cb, width_cr, region, width_valid
  );
endinterface

// File: rtl/skin_width_pipe.sv
// Three-stage pipeline producing luma-dependent Cb/Cr cluster widths.
// Constant divisions become elaboration-time reciprocal slopes; one global stall for flow control.
module skin_width_pipe #(
  parameter int DATA_W  = 8,
  parameter int OUT_W   = 16,
  parameter int SLOPE_F = 16,
  parameter int K_L     = 125,
  parameter int K_H     = 188,
  parameter int Y_MIN   = 16,
  parameter int Y_MAX   = 235,
  parameter int W_CB    = 12024,
  parameter int WL_CB   = 5888,
  parameter int WH_CB   = 3584,
  parameter int W_CR    = 9923,
  parameter int WL_CR   = 5120,
  parameter int WH_CR   = 2560
) (
  input  logic         clk,
  input  logic         rst,
  skin_width_if.slave  bus
);
  localparam int PW = DATA_W + OUT_W + SLOPE_F;
  typedef logic [PW-1:0] wide_t;

  localparam wide_t SL_CB = ((wide_t'(W_CB) - wide_t'(WL_CB)) << SLOPE_F) / wide_t'(K_L - Y_MIN);
  localparam wide_t SH_CB = ((wide_t'(W_CB) - wide_t'(WH_CB)) << SLOPE_F) / wide_t'(Y_MAX - K_H);
  localparam wide_t SL_CR = ((wide_t'(W_CR) - wide_t'(WL_CR)) << SLOPE_F) / wide_t'(K_L - Y_MIN);
  localparam wide_t SH_CR = ((wide_t'(W_CR) - wide_t'(WH_CR)) << SLOPE_F) / wide_t'(Y_MAX - K_H);
  localparam wide_t RND   = wide_t'(1) << (SLOPE_F - 1);
  localparam wide_t SAT   = (wide_t'(1) << OUT_W) - wide_t'(1);

  localparam logic [DATA_W-1:0] YMIN_V = DATA_W'(Y_MIN);
  localparam logic [DATA_W-1:0] YMAX_V = DATA_W'(Y_MAX);
  localparam logic [DATA_W-1:0] KL_V   = DATA_W'(K_L);
  localparam logic [DATA_W-1:0] KH_V   = DATA_W'(K_H);

  // Round half-up, drop the slope fraction, add the knee base and saturate.
  function automatic logic [OUT_W-1:0] finish_width(input wide_t prod, input logic [OUT_W-1:0] base);
    wide_t sum_v;
    sum_v = ((prod + RND) >> SLOPE_F) + wide_t'(base);
    if (sum_v > SAT) begin
      return SAT[OUT_W-1:0];
    end else begin
      return sum_v[OUT_W-1:0];
    end
  endfunction

  logic              adv_s;
  logic [DATA_W-1:0] yc_s;
  logic [DATA_W-1:0] delta_s;
  logic [1:0]        region_s;
  wide_t             slope_cb_s;
  wide_t             slope_cr_s;
  logic [OUT_W-1:0]  base_cb_s;
  logic [OUT_W-1:0]  base_cr_s;

  logic              v1_r;
  logic [1:0]        region1_r;
  logic [DATA_W-1:0] delta1_r;
  logic              v2_r;
  logic [1:0]        region2_r;
  wide_t             prod_cb_r;
  wide_t             prod_cr_r;
  logic              v3_r;
  logic [1:0]        region3_r;
  logic [OUT_W-1:0]  cb_r;
  logic [OUT_W-1:0]  cr_r;

  assign adv_s           = ~v3_r | bus.width_ready;
  assign bus.y_ready     = adv_s & ~rst;
  assign bus.width_valid = v3_r;
  assign bus.width_cb    = cb_r;
  assign bus.width_cr    = cr_r;
  assign bus.region      = region3_r;

  // Clamp luma and classify it into a region with its distance from the clamp end.
  always_comb begin
    yc_s     = bus.y;
    delta_s  = '0;
    region_s = 2'd0;
    if (bus.y < YMIN_V) begin
      yc_s = YMIN_V;
    end else if (bus.y > YMAX_V) begin
      yc_s = YMAX_V;
    end else begin
      yc_s = bus.y;
    end
    if (bus.const_mode) begin
      region_s = 2'd0;
    end else if (yc_s <= KL_V) begin
      region_s = 2'd1;
      delta_s  = yc_s - YMIN_V;
    end else if (yc_s >= KH_V) begin
      region_s = 2'd2;
      delta_s  = YMAX_V - yc_s;
    end else begin
      region_s = 2'd0;
    end
  end

  // Slope and base selection for the middle and last stages.
  always_comb begin
    slope_cb_s = SL_CB;
    slope_cr_s = SL_CR;
    base_cb_s  = OUT_W'(W_CB);
    base_cr_s  = OUT_W'(W_CR);
    if (region1_r == 2'd2) begin
      slope_cb_s = SH_CB;
      slope_cr_s = SH_CR;
    end else begin
      slope_cb_s = SL_CB;
      slope_cr_s = SL_CR;
    end
    case (region2_r)
      2'd1: begin
        base_cb_s = OUT_W'(WL_CB);
        base_cr_s = OUT_W'(WL_CR);
      end
      2'd2: begin
        base_cb_s = OUT_W'(WH_CB);
        base_cr_s = OUT_W'(WH_CR);
      end
      default: begin
        base_cb_s = OUT_W'(W_CB);
        base_cr_s = OUT_W'(W_CR);
      end
    endcase
  end

  // Pipeline registers; every stage, empty or not, shifts only on adv.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r      <= 1'b0;
      region1_r <= 2'd0;
      delta1_r  <= '0;
      v2_r      <= 1'b0;
      region2_r <= 2'd0;
      prod_cb_r <= '0;
      prod_cr_r <= '0;
      v3_r      <= 1'b0;
      region3_r <= 2'd0;
      cb_r      <= '0;
      cr_r      <= '0;
    end else if (adv_s) begin
      v1_r      <= bus.y_valid;
      region1_r <= region_s;
      delta1_r  <= delta_s;
      v2_r      <= v1_r;
      region2_r <= region1_r;
      prod_cb_r <= wide_t'(delta1_r) * slope_cb_s;
      prod_cr_r <= wide_t'(delta1_r) * slope_cr_s;
      v3_r      <= v2_r;
      region3_r <= region2_r;
      // Mid region (including forced-nominal) ignores the product entirely.
      if (region2_r == 2'd0) begin
        cb_r <= OUT_W'(W_CB);
        cr_r <= OUT_W'(W_CR);
      end else begin
        cb_r <= finish_width(prod_cb_r, base_cb_s);
        cr_r <= finish_width(prod_cr_r, base_cr_s);
      end
    end else begin
      v1_r <= v1_r;
    end
  end
endmodule

// File: tb/tb_skin_width_pipe.sv
// Self-checking bench for skin_width_pipe: directed table, random backpressure
// against a plain-arithmetic width model, stall limit and mid-stream reset.
module tb_skin_width_pipe;
  logic clk;
  logic rst;

  skin_width_if #(.DATA_W(8), .OUT_W(16)) bus ();

  skin_width_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] cb;
    logic [15:0] cr;
    logic [1:0]  rg;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [7:0]  y;
    logic        cm;
    logic [15:0] cb;
    logic [15:0] cr;
    logic [1:0]  rg;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  bit          lat_chk = 1'b0;
  bit          held    = 1'b0;
  logic [15:0] h_cb;
  logic [15:0] h_cr;
  logic [1:0]  h_rg;
  exp_t        sb[$];
  vec_t        tbl[10];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input longint act, input longint req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Width from the knee value, moving linearly toward nominal over den luma steps.
  function automatic longint wfn(input longint base, input longint nom, input longint den, input longint d);
    longint s;
    longint w;
    s = ((nom - base) * 65536) / den;
    w = base + (d * s + 32768) / 65536;
    if (w > 65535) w = 65535;
    return w;
  endfunction

  function automatic exp_t model(input logic [7:0] yy, input logic cm);
    exp_t e;
    int   yc;
    yc = int'(yy);
    if (yc < 16) yc = 16;
    if (yc > 235) yc = 235;
    e.cyc = 0;
    if (cm) begin
      e.rg = 2'd0; e.cb = 16'd12024; e.cr = 16'd9923;
    end else if (yc <= 125) begin
      e.rg = 2'd1;
      e.cb = 16'(wfn(5888, 12024, 109, yc - 16));
      e.cr = 16'(wfn(5120, 9923, 109, yc - 16));
    end else if (yc >= 188) begin
      e.rg = 2'd2;
      e.cb = 16'(wfn(3584, 12024, 47, 235 - yc));
      e.cr = 16'(wfn(2560, 9923, 47, 235 - yc));
    end else begin
      e.rg = 2'd0; e.cb = 16'd12024; e.cr = 16'd9923;
    end
    return e;
  endfunction

  // One clock: check hold, drive inputs, score output transfer, record input transfer.
  task automatic cycle(input logic r, input logic v, input logic [7:0] yy, input logic cm,
                       input logic wr, input exp_t ex, output logic acc);
    exp_t e;
    @(negedge clk);
    cyc++;
    if (held) begin
      chk("hold_cb", bus.width_cb, h_cb);
      chk("hold_cr", bus.width_cr, h_cr);
      chk("hold_region", bus.region, h_rg);
      chk("hold_valid", bus.width_valid, 1);
    end
    rst = r; bus.y_valid = v; bus.y = yy; bus.const_mode = cm; bus.width_ready = wr;
    #1;
    acc = v & bus.y_ready;
    if (r) begin
      chk("rst_y_ready", bus.y_ready, 0);
      held = 1'b0;
      sb.delete();
    end else begin
      if (bus.width_valid && wr) begin
        if (sb.size() == 0) begin
          chk("spurious_out", bus.width_valid, 0);
        end else begin
          e = sb.pop_front();
          chk("width_cb", bus.width_cb, e.cb);
          chk("width_cr", bus.width_cr, e.cr);
          chk("region", bus.region, e.rg);
          if (lat_chk) chk("latency", cyc - e.cyc, 3);
        end
      end
      if (acc) begin
        e = ex;
        e.cyc = cyc;
        sb.push_back(e);
      end
      held = bus.width_valid & ~wr;
      h_cb = bus.width_cb; h_cr = bus.width_cr; h_rg = bus.region;
    end
  endtask

  initial begin
    exp_t       ex;
    exp_t       none;
    logic       acc;
    logic [7:0] py;
    logic       pcm;
    logic       v;
    logic       wr;
    int         n_acc;
    int         budget;

    none = '{cb: 16'd0, cr: 16'd0, rg: 2'd0, cyc: 0};
    tbl[0] = '{y: 8'd16,  cm: 1'b0, cb: 16'd5888,  cr: 16'd5120, rg: 2'd1};
    tbl[1] = '{y: 8'd125, cm: 1'b0, cb: 16'd12024, cr: 16'd9923, rg: 2'd1};
    tbl[2] = '{y: 8'd150, cm: 1'b0, cb: 16'd12024, cr: 16'd9923, rg: 2'd0};
    tbl[3] = '{y: 8'd188, cm: 1'b0, cb: 16'd12024, cr: 16'd9923, rg: 2'd2};
    tbl[4] = '{y: 8'd235, cm: 1'b0, cb: 16'd3584,  cr: 16'd2560, rg: 2'd2};
    tbl[5] = '{y: 8'd0,   cm: 1'b0, cb: 16'd5888,  cr: 16'd5120, rg: 2'd1};
    tbl[6] = '{y: 8'd255, cm: 1'b0, cb: 16'd3584,  cr: 16'd2560, rg: 2'd2};
    ex = model(8'd70, 1'b0);
    tbl[7] = '{y: 8'd70,  cm: 1'b0, cb: 16'd8928,  cr: ex.cr,    rg: 2'd1};
    tbl[8] = '{y: 8'd16,  cm: 1'b1, cb: 16'd12024, cr: 16'd9923, rg: 2'd0};
    tbl[9] = '{y: 8'd16,  cm: 1'b0, cb: 16'd5888,  cr: 16'd5120, rg: 2'd1};

    rst = 1'b1; bus.y = 8'd0; bus.y_valid = 1'b0; bus.const_mode = 1'b0; bus.width_ready = 1'b1;
    repeat (3) cycle(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, none, acc);
    chk("reset_valid", bus.width_valid, 0);
    chk("reset_cb", bus.width_cb, 0);
    chk("reset_cr", bus.width_cr, 0);
    chk("reset_region", bus.region, 0);
    cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, none, acc);
    chk("ready_after_reset", bus.y_ready, 1);

    // Directed table, back-to-back, with exact three-cycle latency.
    lat_chk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ex = '{cb: tbl[i].cb, cr: tbl[i].cr, rg: tbl[i].rg, cyc: 0};
      cycle(1'b0, 1'b1, tbl[i].y, tbl[i].cm, 1'b1, ex, acc);
      chk("table_accept", acc, 1);
    end
    repeat (6) cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, none, acc);
    chk("table_drained", sb.size(), 0);
    lat_chk = 1'b0;

    // Random luma and flow control against the model.
    n_acc = 0;
    budget = 20000;
    py = 8'($urandom_range(0, 255));
    pcm = ($urandom_range(0, 9) == 0);
    while (n_acc < 1000 && budget > 0) begin
      v  = ($urandom_range(0, 3) != 0);
      wr = 1'($urandom_range(0, 1));
      cycle(1'b0, v, py, pcm, wr, model(py, pcm), acc);
      if (acc) begin
        n_acc++;
        py = 8'($urandom_range(0, 255));
        pcm = ($urandom_range(0, 9) == 0);
      end
      budget--;
    end
    chk("random_accepted", n_acc, 1000);
    repeat (8) cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, none, acc);
    chk("random_drained", sb.size(), 0);

    // Permanent backpressure: pipeline fills and then refuses input.
    n_acc = 0;
    for (int i = 0; i < 12; i++) begin
      py = 8'($urandom_range(0, 255));
      cycle(1'b0, 1'b1, py, 1'b0, 1'b0, model(py, 1'b0), acc);
      if (acc) n_acc++;
    end
    chk("stall_accepts", n_acc, 3);
    repeat (8) cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, none, acc);
    chk("stall_drained", sb.size(), 0);

    // Reset with three samples in flight; none may emerge afterwards.
    cycle(1'b0, 1'b1, 8'd50, 1'b0, 1'b1, model(8'd50, 1'b0), acc);
    cycle(1'b0, 1'b1, 8'd100, 1'b0, 1'b1, model(8'd100, 1'b0), acc);
    cycle(1'b0, 1'b1, 8'd200, 1'b0, 1'b1, model(8'd200, 1'b0), acc);
    cycle(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, none, acc);
    cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, none, acc);
    chk("post_reset_valid", bus.width_valid, 0);
    chk("post_reset_ready", bus.y_ready, 1);
    repeat (6) cycle(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, none, acc);
    chk("post_reset_quiet", bus.width_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
